// File: rtl/trap_ctrl_if.sv
// Trap controller bus: exception requests from IF/ID/MEM, MRET, CSR
// exception port and fetch redirect handshake.
interface trap_ctrl_if;
    logic        if_xcpt_i;
    logic [4:0]  if_code_i;
    logic [31:0] if_pc_i;
    logic [31:0] if_tval_i;
    logic        id_xcpt_i;
    logic [4:0]  id_code_i;
    logic [31:0] id_pc_i;
    logic [31:0] id_tval_i;
    logic        mem_xcpt_i;
    logic [4:0]  mem_code_i;
    logic [31:0] mem_pc_i;
    logic [31:0] mem_tval_i;
    logic        mret_i;
    logic [31:0] mepc_i;
    logic [31:0] tvec_i;
    logic        redirect_ready_i;
    logic        csr_xcpt_o;
    logic [4:0]  csr_xcpt_code_o;
    logic [31:0] csr_xcpt_pc_o;
    logic [31:0] csr_xcpt_value_o;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        busy_o;

    // Core/pipeline side: raises requests, consumes CSR strobe and redirect.
    modport master (
        output if_xcpt_i, if_code_i, if_pc_i, if_tval_i,
        output id_xcpt_i, id_code_i, id_pc_i, id_tval_i,
        output mem_xcpt_i, mem_code_i, mem_pc_i, mem_tval_i,
        output mret_i, mepc_i, tvec_i, redirect_ready_i,
        input  csr_xcpt_o, csr_xcpt_code_o, csr_xcpt_pc_o, csr_xcpt_value_o,
        input  flush_o, redirect_valid_o, redirect_pc_o, busy_o
    );

    // Trap controller side.
    modport slave (
        input  if_xcpt_i, if_code_i, if_pc_i, if_tval_i,
        input  id_xcpt_i, id_code_i, id_pc_i, id_tval_i,
        input  mem_xcpt_i, mem_code_i, mem_pc_i, mem_tval_i,
        input  mret_i, mepc_i, tvec_i, redirect_ready_i,
        output csr_xcpt_o, csr_xcpt_code_o, csr_xcpt_pc_o, csr_xcpt_value_o,
        output flush_o, redirect_valid_o, redirect_pc_o, busy_o
    );
endinterface

// File: rtl/trap_ctrl.sv
// Trap entry / MRET sequencer: picks the oldest exception (MEM > ID > IF),
// strobes the CSR file, flushes the pipeline for FLUSH_CYCLES cycles, then
// hands the redirect PC to fetch over a valid/ready handshake.
module trap_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 3,
    parameter logic [31:0] RESET_TVEC   = 32'h0000_2000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    trap_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        REDIRECT
    } state_e;

    typedef enum logic {
        KIND_TRAP,
        KIND_MRET
    } kind_e;

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] target_q;
    logic        csr_xcpt_q;
    logic [4:0]  code_q;
    logic [31:0] pc_q;
    logic [31:0] tval_q;
    logic        flush_q;
    logic        rvalid_q;
    logic [31:0] rpc_q;
    logic        busy_q;

    logic        req_d;
    kind_e       kind_d;
    logic [4:0]  code_d;
    logic [31:0] pc_d;
    logic [31:0] tval_d;
    logic [31:0] target_d;

    // Request arbitration: oldest stage wins, exceptions beat MRET.
    always_comb begin
        req_d    = 1'b1;
        kind_d   = KIND_TRAP;
        code_d   = '0;
        pc_d     = '0;
        tval_d   = '0;
        target_d = (bus.tvec_i != '0) ? bus.tvec_i : RESET_TVEC;
        if (bus.mem_xcpt_i) begin
            code_d = bus.mem_code_i;
            pc_d   = bus.mem_pc_i;
            tval_d = bus.mem_tval_i;
        end else if (bus.id_xcpt_i) begin
            code_d = bus.id_code_i;
            pc_d   = bus.id_pc_i;
            tval_d = bus.id_tval_i;
        end else if (bus.if_xcpt_i) begin
            code_d = bus.if_code_i;
            pc_d   = bus.if_pc_i;
            tval_d = bus.if_tval_i;
        end else if (bus.mret_i) begin
            kind_d   = KIND_MRET;
            target_d = bus.mepc_i;
        end else begin
            req_d = 1'b0;
        end
    end

    // Sequencer FSM with registered outputs; reset aborts any sequence.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            target_q   <= '0;
            csr_xcpt_q <= 1'b0;
            code_q     <= '0;
            pc_q       <= '0;
            tval_q     <= '0;
            flush_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            rpc_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_d) begin
                        state_q    <= FLUSH;
                        cnt_q      <= CNT_LOAD;
                        target_q   <= target_d;
                        flush_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        csr_xcpt_q <= (kind_d == KIND_TRAP);
                        code_q     <= code_d;
                        pc_q       <= pc_d;
                        tval_q     <= tval_d;
                    end
                end
                FLUSH: begin
                    csr_xcpt_q <= 1'b0;
                    if (cnt_q == '0) begin
                        state_q  <= REDIRECT;
                        flush_q  <= 1'b0;
                        rvalid_q <= 1'b1;
                        rpc_q    <= target_q & 32'hFFFF_FFFC;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                REDIRECT: begin
                    if (bus.redirect_ready_i) begin
                        state_q  <= IDLE;
                        rvalid_q <= 1'b0;
                        rpc_q    <= '0;
                        busy_q   <= 1'b0;
                        code_q   <= '0;
                        pc_q     <= '0;
                        tval_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.csr_xcpt_o       = csr_xcpt_q;
    assign bus.csr_xcpt_code_o  = code_q;
    assign bus.csr_xcpt_pc_o    = pc_q;
    assign bus.csr_xcpt_value_o = tval_q;
    assign bus.flush_o          = flush_q;
    assign bus.redirect_valid_o = rvalid_q;
    assign bus.redirect_pc_o    = rpc_q;
    assign bus.busy_o           = busy_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed testbench for trap_ctrl.
module tb_trap_ctrl;

    logic clk_i = 1'b0;
    logic rstn_i;
    int   checks = 0;
    int   errors = 0;
    int   n_csr = 0;
    int   n_redir = 0;

    trap_ctrl_if bus ();

    trap_ctrl #(.FLUSH_CYCLES(3), .RESET_TVEC(32'h0000_2000)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    // Event counters sampled away from the active edge.
    always @(negedge clk_i) begin
        if (bus.csr_xcpt_o === 1'b1) n_csr++;
        if (bus.redirect_valid_o === 1'b1) n_redir++;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        bus.if_xcpt_i = 0;  bus.if_code_i = '0;  bus.if_pc_i = '0;  bus.if_tval_i = '0;
        bus.id_xcpt_i = 0;  bus.id_code_i = '0;  bus.id_pc_i = '0;  bus.id_tval_i = '0;
        bus.mem_xcpt_i = 0; bus.mem_code_i = '0; bus.mem_pc_i = '0; bus.mem_tval_i = '0;
        bus.mret_i = 0;     bus.mepc_i = '0;
    endtask

    task automatic wait_redirect(output bit ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.redirect_valid_o === 1'b1) begin
                ok = 1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.busy_o === 1'b0) begin
                ok = 1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        logic [104:0] all;
        rstn_i = 0;
        clear_inputs();
        bus.tvec_i = '0;
        bus.redirect_ready_i = 1;
        step();
        step();
        all = {bus.csr_xcpt_o, bus.csr_xcpt_code_o, bus.csr_xcpt_pc_o, bus.csr_xcpt_value_o,
               bus.flush_o, bus.redirect_valid_o, bus.redirect_pc_o, bus.busy_o};
        checks++;
        if (all !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", all);
        end
        rstn_i = 1;
        step();
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy got %b want 0", bus.busy_o);
        end
    endtask

    task automatic test_mem_trap();
        logic [104:0] all;
        bit ok;
        int base_csr;
        base_csr = n_csr;
        bus.tvec_i = 32'h400;
        bus.redirect_ready_i = 1;
        bus.mem_xcpt_i = 1; bus.mem_code_i = 5'd5; bus.mem_pc_i = 32'h100; bus.mem_tval_i = 32'hDEAD;
        step();
        clear_inputs();
        checks++;
        if ({bus.csr_xcpt_o, bus.csr_xcpt_code_o, bus.csr_xcpt_pc_o, bus.csr_xcpt_value_o} !==
            {1'b1, 5'd5, 32'h100, 32'hDEAD}) begin
            errors++;
            $display("FAIL mem_csr_port got %b/%0d/%h/%h want 1/5/100/dead", bus.csr_xcpt_o,
                     bus.csr_xcpt_code_o, bus.csr_xcpt_pc_o, bus.csr_xcpt_value_o);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (bus.flush_o !== 1'b1 || bus.busy_o !== 1'b1 || bus.redirect_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL mem_flush_cycle%0d got flush=%b busy=%b rv=%b want 1/1/0", c,
                         bus.flush_o, bus.busy_o, bus.redirect_valid_o);
            end
            if (c == 1) begin
                checks++;
                if (bus.csr_xcpt_o !== 1'b0 || bus.csr_xcpt_code_o !== 5'd5) begin
                    errors++;
                    $display("FAIL mem_strobe_len got strobe=%b code=%0d want 0/5",
                             bus.csr_xcpt_o, bus.csr_xcpt_code_o);
                end
            end
            step();
        end
        checks++;
        if (bus.flush_o !== 1'b0 || bus.redirect_valid_o !== 1'b1 || bus.redirect_pc_o !== 32'h400) begin
            errors++;
            $display("FAIL mem_redirect got flush=%b rv=%b pc=%h want 0/1/400", bus.flush_o,
                     bus.redirect_valid_o, bus.redirect_pc_o);
        end
        step();
        all = {bus.csr_xcpt_o, bus.csr_xcpt_code_o, bus.csr_xcpt_pc_o, bus.csr_xcpt_value_o,
               bus.flush_o, bus.redirect_valid_o, bus.redirect_pc_o, bus.busy_o};
        checks++;
        if (all !== '0) begin
            errors++;
            $display("FAIL mem_back_idle got %h want 0", all);
        end
        checks++;
        if (n_csr - base_csr !== 1) begin
            errors++;
            $display("FAIL mem_strobe_count got %0d want 1", n_csr - base_csr);
        end
        wait_idle(ok);
    endtask

    task automatic test_priority();
        bit ok;
        bus.tvec_i = 32'h400;
        bus.if_xcpt_i = 1;  bus.if_code_i = 5'd1;  bus.if_pc_i = 32'h10; bus.if_tval_i = 32'h11;
        bus.id_xcpt_i = 1;  bus.id_code_i = 5'd2;  bus.id_pc_i = 32'h0C; bus.id_tval_i = 32'h22;
        bus.mem_xcpt_i = 1; bus.mem_code_i = 5'd4; bus.mem_pc_i = 32'h08; bus.mem_tval_i = 32'h44;
        step();
        clear_inputs();
        checks++;
        if ({bus.csr_xcpt_o, bus.csr_xcpt_code_o, bus.csr_xcpt_pc_o, bus.csr_xcpt_value_o} !==
            {1'b1, 5'd4, 32'h08, 32'h44}) begin
            errors++;
            $display("FAIL priority_mem got %b/%0d/%h/%h want 1/4/8/44", bus.csr_xcpt_o,
                     bus.csr_xcpt_code_o, bus.csr_xcpt_pc_o, bus.csr_xcpt_value_o);
        end
        wait_redirect(ok);
        step();
        wait_idle(ok);
        bus.if_xcpt_i = 1;  bus.if_code_i = 5'd1;  bus.if_pc_i = 32'h10; bus.if_tval_i = 32'h11;
        bus.id_xcpt_i = 1;  bus.id_code_i = 5'd2;  bus.id_pc_i = 32'h0C; bus.id_tval_i = 32'h22;
        step();
        clear_inputs();
        checks++;
        if ({bus.csr_xcpt_code_o, bus.csr_xcpt_pc_o} !== {5'd2, 32'h0C}) begin
            errors++;
            $display("FAIL priority_id got %0d/%h want 2/c", bus.csr_xcpt_code_o, bus.csr_xcpt_pc_o);
        end
        wait_redirect(ok);
        step();
        wait_idle(ok);
    endtask

    task automatic test_mret();
        bit ok;
        int base_csr;
        base_csr = n_csr;
        bus.tvec_i = 32'h400;
        bus.mret_i = 1; bus.mepc_i = 32'h206;
        step();
        clear_inputs();
        checks++;
        if (bus.csr_xcpt_o !== 1'b0 || bus.flush_o !== 1'b1 || bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL mret_entry got strobe=%b flush=%b busy=%b want 0/1/1", bus.csr_xcpt_o,
                     bus.flush_o, bus.busy_o);
        end
        wait_redirect(ok);
        checks++;
        if (!ok || bus.redirect_pc_o !== 32'h204) begin
            errors++;
            $display("FAIL mret_target got ok=%0d pc=%h want 1/204", ok, bus.redirect_pc_o);
        end
        step();
        wait_idle(ok);
        checks++;
        if (n_csr - base_csr !== 0) begin
            errors++;
            $display("FAIL mret_no_strobe got %0d want 0", n_csr - base_csr);
        end
        bus.mret_i = 1; bus.mepc_i = 32'h206;
        bus.id_xcpt_i = 1; bus.id_code_i = 5'd3; bus.id_pc_i = 32'h30; bus.id_tval_i = 32'h33;
        step();
        clear_inputs();
        checks++;
        if ({bus.csr_xcpt_o, bus.csr_xcpt_code_o, bus.csr_xcpt_pc_o} !== {1'b1, 5'd3, 32'h30}) begin
            errors++;
            $display("FAIL mret_vs_xcpt got %b/%0d/%h want 1/3/30", bus.csr_xcpt_o,
                     bus.csr_xcpt_code_o, bus.csr_xcpt_pc_o);
        end
        wait_redirect(ok);
        checks++;
        if (!ok || bus.redirect_pc_o !== 32'h400) begin
            errors++;
            $display("FAIL mret_vs_xcpt_target got ok=%0d pc=%h want 1/400", ok, bus.redirect_pc_o);
        end
        step();
        wait_idle(ok);
    endtask

    task automatic test_tvec_zero_stall();
        bit ok;
        bus.tvec_i = '0;
        bus.redirect_ready_i = 0;
        bus.id_xcpt_i = 1; bus.id_code_i = 5'd2; bus.id_pc_i = 32'h40; bus.id_tval_i = 32'h0;
        step();
        clear_inputs();
        wait_redirect(ok);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (!ok || bus.redirect_valid_o !== 1'b1 || bus.redirect_pc_o !== 32'h2000 ||
                bus.flush_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d got rv=%b pc=%h flush=%b want 1/2000/0", c,
                         bus.redirect_valid_o, bus.redirect_pc_o, bus.flush_o);
            end
            if (c < 3) step();
        end
        bus.redirect_ready_i = 1;
        step();
        checks++;
        if (bus.busy_o !== 1'b0 || bus.redirect_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got busy=%b rv=%b want 0/0", bus.busy_o, bus.redirect_valid_o);
        end
        wait_idle(ok);
    endtask

    task automatic test_ignore_busy();
        bit ok;
        int base_csr;
        base_csr = n_csr;
        bus.tvec_i = 32'h400;
        bus.redirect_ready_i = 0;
        bus.id_xcpt_i = 1; bus.id_code_i = 5'd2; bus.id_pc_i = 32'h50; bus.id_tval_i = 32'h5;
        step();
        bus.id_code_i = 5'd7; bus.id_pc_i = 32'h77; bus.id_tval_i = 32'h7;
        wait_redirect(ok);
        step();
        checks++;
        if (!ok || bus.csr_xcpt_code_o !== 5'd2 || bus.csr_xcpt_pc_o !== 32'h50 ||
            bus.redirect_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL ignore_hold got ok=%0d code=%0d pc=%h rv=%b want 1/2/50/1", ok,
                     bus.csr_xcpt_code_o, bus.csr_xcpt_pc_o, bus.redirect_valid_o);
        end
        clear_inputs();
        bus.redirect_ready_i = 1;
        step();
        step();
        checks++;
        if (n_csr - base_csr !== 1 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL ignore_count got strobes=%0d busy=%b want 1/0", n_csr - base_csr, bus.busy_o);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int base_csr;
        base_csr = n_csr;
        bus.tvec_i = 32'h400;
        bus.redirect_ready_i = 1;
        bus.id_xcpt_i = 1; bus.id_code_i = 5'd9; bus.id_pc_i = 32'h60; bus.id_tval_i = 32'h6;
        step();
        wait_redirect(ok);
        step();
        checks++;
        if (!ok || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got ok=%0d busy=%b want 1/0", ok, bus.busy_o);
        end
        step();
        clear_inputs();
        checks++;
        if (bus.csr_xcpt_o !== 1'b1 || bus.busy_o !== 1'b1 || bus.csr_xcpt_code_o !== 5'd9) begin
            errors++;
            $display("FAIL b2b_accept got strobe=%b busy=%b code=%0d want 1/1/9", bus.csr_xcpt_o,
                     bus.busy_o, bus.csr_xcpt_code_o);
        end
        wait_idle(ok);
        checks++;
        if (!ok || n_csr - base_csr !== 2) begin
            errors++;
            $display("FAIL b2b_count got ok=%0d strobes=%0d want 1/2", ok, n_csr - base_csr);
        end
    endtask

    task automatic test_reset_abort();
        logic [104:0] all;
        int base_redir;
        int base_csr;
        bus.tvec_i = 32'h400;
        bus.redirect_ready_i = 1;
        bus.mem_xcpt_i = 1; bus.mem_code_i = 5'd1; bus.mem_pc_i = 32'h70; bus.mem_tval_i = 32'h7;
        step();
        clear_inputs();
        step();
        checks++;
        if (bus.flush_o !== 1'b1 || bus.csr_xcpt_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_pre got flush=%b strobe=%b want 1/0", bus.flush_o, bus.csr_xcpt_o);
        end
        rstn_i = 0;
        #1;
        all = {bus.csr_xcpt_o, bus.csr_xcpt_code_o, bus.csr_xcpt_pc_o, bus.csr_xcpt_value_o,
               bus.flush_o, bus.redirect_valid_o, bus.redirect_pc_o, bus.busy_o};
        checks++;
        if (all !== '0) begin
            errors++;
            $display("FAIL abort_async got %h want 0", all);
        end
        step();
        rstn_i = 1;
        base_redir = n_redir;
        base_csr = n_csr;
        for (int c = 0; c < 10; c++) step();
        checks++;
        if (n_redir - base_redir !== 0 || n_csr - base_csr !== 0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_after got redir=%0d strobes=%0d busy=%b want 0/0/0",
                     n_redir - base_redir, n_csr - base_csr, bus.busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_mem_trap();
        test_priority();
        test_mret();
        test_tvec_zero_stall();
        test_ignore_busy();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
